// File: rtl/riscv151_csr_pkg.sv
// Shared CSR definitions for the Riscv151 CSR unit: CSR addresses, Zicsr funct3
// encodings, the RW/RS/RC operation kind and the new-value ALU.
package riscv151_csr_pkg;

  localparam logic [11:0] CSR_TOHOST   = 12'h51e;
  localparam logic [11:0] CSR_CYCLE    = 12'hc00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hc80;
  localparam logic [11:0] CSR_INSTRET  = 12'hc02;
  localparam logic [11:0] CSR_INSTRETH = 12'hc82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    CSR_OP_RW,
    CSR_OP_RS,
    CSR_OP_RC
  } csr_op_e;

  function automatic logic [31:0] csr_alu(input csr_op_e op, input logic [31:0] old,
                                          input logic [31:0] src);
    case (op)
      CSR_OP_RS: return old | src;
      CSR_OP_RC: return old & ~src;
      default:   return src;
    endcase
  endfunction

endpackage

// File: rtl/csr_tohost_unit_if.sv
// Execute-stage CSR port: Zicsr instruction fields and pipeline control in,
// old CSR value, illegal flag and the tohost register out.
interface csr_tohost_unit_if;
  logic        csr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_idx;
  logic        stall;
  logic        kill;
  logic        retire;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic [31:0] tohost;

  modport master (
    output csr_en, csr_op, csr_addr, rs1_data, rs1_idx, stall, kill, retire,
    input  csr_rdata, illegal, tohost
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, rs1_data, rs1_idx, stall, kill, retire,
    output csr_rdata, illegal, tohost
  );
endinterface

// File: rtl/csr_counter64.sv
// Free-running 64-bit counter; count advances on the edge after inc, wraps to 0,
// carries into the upper half in the same cycle. Reset loads RST_VAL.
module csr_counter64 #(
  parameter logic [63:0] RST_VAL = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_tohost_unit.sv
// Zicsr execute unit holding tohost and the cycle/instret counters. Reads are
// combinational; tohost updates on the edge after a non-stalled, non-killed commit.
module csr_tohost_unit
  import riscv151_csr_pkg::*;
#(
  parameter logic [63:0] CYCLE_INIT = 64'd0
) (
  input logic              clk,
  input logic              rst,
  csr_tohost_unit_if.slave bus
);

  localparam logic [11:0] TOHOST_ADDR = CSR_TOHOST;

  csr_op_e     op_kind;
  logic        op_ok;
  logic [31:0] src;
  logic        wr_intent;
  logic        addr_known;
  logic        addr_ro;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        commit;
  logic [31:0] tohost_q;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  always_comb begin
    op_kind = CSR_OP_RW;
    op_ok   = 1'b1;
    case (bus.csr_op)
      F3_RW, F3_RWI: op_kind = CSR_OP_RW;
      F3_RS, F3_RSI: op_kind = CSR_OP_RS;
      F3_RC, F3_RCI: op_kind = CSR_OP_RC;
      default:       op_ok   = 1'b0;
    endcase
  end

  // funct3[2] selects the zero-extended rs1 field as the immediate source.
  assign src = bus.csr_op[2] ? {27'b0, bus.rs1_idx} : bus.rs1_data;

  // Set/clear with x0 as source is a pure read, so it stays legal on counters.
  assign wr_intent = (op_kind == CSR_OP_RW) || (bus.rs1_idx != 5'd0);

  always_comb begin
    addr_known = 1'b1;
    addr_ro    = 1'b1;
    old_val    = 32'd0;
    case (bus.csr_addr)
      TOHOST_ADDR: begin
        old_val = tohost_q;
        addr_ro = 1'b0;
      end
      CSR_CYCLE:    old_val = cycle_cnt[31:0];
      CSR_CYCLEH:   old_val = cycle_cnt[63:32];
      CSR_INSTRET:  old_val = instret_cnt[31:0];
      CSR_INSTRETH: old_val = instret_cnt[63:32];
      default:      addr_known = 1'b0;
    endcase
  end

  assign new_val = csr_alu(op_kind, old_val, src);

  assign bus.illegal   = bus.csr_en && (!op_ok || !addr_known || (addr_ro && wr_intent));
  assign bus.csr_rdata = (bus.csr_en && addr_known) ? old_val : 32'd0;

  assign commit = bus.csr_en && !bus.stall && !bus.kill && !bus.illegal && wr_intent &&
                  (bus.csr_addr == TOHOST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      tohost_q <= 32'd0;
    end else if (commit) begin
      tohost_q <= new_val;
    end
  end

  assign bus.tohost = tohost_q;

  csr_counter64 #(.RST_VAL(CYCLE_INIT)) u_cycle (
    .clk  (clk),
    .rst  (rst),
    .inc  (1'b1),
    .count(cycle_cnt)
  );

  csr_counter64 u_instret (
    .clk  (clk),
    .rst  (rst),
    .inc  (bus.retire),
    .count(instret_cnt)
  );

endmodule

// File: tb/tb_csr_tohost_unit.sv
// Self-checking bench for csr_tohost_unit: directed test-plan cases plus random
// traffic, checked every cycle against a behavioural CSR model.
module tb_csr_tohost_unit;

  localparam logic [63:0] WRAP_INIT = 64'h0000_0000_ffff_fffc;

  logic clk;
  logic rst;
  logic checking;
  int   n_chk;
  int   n_fail;

  csr_tohost_unit_if m_if ();
  csr_tohost_unit_if w_if ();

  csr_tohost_unit dut (
    .clk(clk),
    .rst(rst),
    .bus(m_if.slave)
  );

  // Second instance starts its cycle counter just below 2^32 to reach the carry quickly.
  csr_tohost_unit #(.CYCLE_INIT(WRAP_INIT)) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(w_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural state: what the architected registers hold after the last edge.
  logic [31:0] m_tohost;
  logic [63:0] m_cyc;
  logic [63:0] m_ins;
  logic [63:0] w_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval(
    input  logic        en,
    input  logic [2:0]  op,
    input  logic [11:0] addr,
    input  logic [31:0] rs1,
    input  logic [4:0]  idx,
    input  logic [31:0] th,
    input  logic [63:0] cyc,
    input  logic [63:0] ins,
    output logic [31:0] rd,
    output logic        ill,
    output logic        wr,
    output logic [31:0] nv
  );
    logic [31:0] s;
    logic [31:0] old;
    logic        known;
    logic        is_tohost;
    logic        writes;
    s = op[2] ? {27'b0, idx} : rs1;
    known = 1'b1;
    is_tohost = 1'b0;
    old = 32'd0;
    if (addr == 12'h51e) begin
      old = th;
      is_tohost = 1'b1;
    end else if (addr == 12'hc00) old = cyc[31:0];
    else if (addr == 12'hc80) old = cyc[63:32];
    else if (addr == 12'hc02) old = ins[31:0];
    else if (addr == 12'hc82) old = ins[63:32];
    else known = 1'b0;
    writes = (op[1:0] == 2'b01) || (idx != 5'd0);
    if (op[1:0] == 2'b01) nv = s;
    else if (op[1:0] == 2'b10) nv = old | s;
    else nv = old & ~s;
    ill = en && ((op[1:0] == 2'b00) || !known || (!is_tohost && writes));
    rd = (en && known) ? old : 32'd0;
    wr = en && !ill && writes && is_tohost;
  endfunction

  logic [31:0] e_rd;
  logic [31:0] e_nv;
  logic        e_ill;
  logic        e_wr;

  always @(negedge clk) begin
    model_eval(m_if.csr_en, m_if.csr_op, m_if.csr_addr, m_if.rs1_data, m_if.rs1_idx,
               m_tohost, m_cyc, m_ins, e_rd, e_ill, e_wr, e_nv);
    if (checking) begin
      chk("rdata", m_if.csr_rdata, e_rd);
      chk("illegal", {31'b0, m_if.illegal}, {31'b0, e_ill});
      chk("tohost", m_if.tohost, m_tohost);
      chk("wrap_rdata", w_if.csr_rdata,
          (w_if.csr_addr == 12'hc80) ? w_cyc[63:32] : w_cyc[31:0]);
      chk("wrap_illegal", {31'b0, w_if.illegal}, 32'd0);
      chk("wrap_tohost", w_if.tohost, 32'd0);
    end
    if (rst) begin
      m_tohost = 32'd0;
      m_cyc    = 64'd0;
      m_ins    = 64'd0;
      w_cyc    = WRAP_INIT;
    end else begin
      m_cyc = m_cyc + 64'd1;
      w_cyc = w_cyc + 64'd1;
      if (m_if.retire) m_ins = m_ins + 64'd1;
      if (e_wr && !m_if.stall && !m_if.kill) m_tohost = e_nv;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] d, input logic [4:0] idx, input logic st,
                       input logic kl, input logic rt);
    m_if.csr_en   = en;
    m_if.csr_op   = op;
    m_if.csr_addr = addr;
    m_if.rs1_data = d;
    m_if.rs1_idx  = idx;
    m_if.stall    = st;
    m_if.kill     = kl;
    m_if.retire   = rt;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 12'h000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        found;
  logic [11:0] raddr;

  initial begin
    n_chk = 0;
    n_fail = 0;
    checking = 1'b0;
    m_tohost = 32'd0;
    m_cyc = 64'd0;
    m_ins = 64'd0;
    w_cyc = WRAP_INIT;
    rst = 1'b1;
    idle();
    w_if.csr_en   = 1'b1;
    w_if.csr_op   = 3'b010;
    w_if.csr_addr = 12'hc00;
    w_if.rs1_data = 32'd0;
    w_if.rs1_idx  = 5'd0;
    w_if.stall    = 1'b0;
    w_if.kill     = 1'b0;
    w_if.retire   = 1'b0;

    tick();
    checking = 1'b1;
    @(negedge clk);
    chk("reset_rdata", m_if.csr_rdata, 32'd0);
    chk("reset_illegal", {31'b0, m_if.illegal}, 32'd0);
    chk("reset_tohost", m_if.tohost, 32'd0);
    tick();
    rst = 1'b0;

    // Low half of cycle crosses 0xFFFFFFFF; upper half must pick up the carry on that edge.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (w_if.csr_rdata == 32'hffff_ffff) found = 1'b1;
      else tick();
    end
    chk("wrap_found", {31'b0, found}, 32'd1);
    tick();
    w_if.csr_addr = 12'hc80;
    @(negedge clk);
    chk("cycleh_after_carry", w_if.csr_rdata, 32'd1);
    tick();
    w_if.csr_addr = 12'hc00;
    @(negedge clk);
    chk("cycle_lo_after_wrap", w_if.csr_rdata, 32'd1);

    tick();
    drive(1'b1, 3'b001, 12'h51e, 32'h1, 5'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("first_write_rdata", m_if.csr_rdata, 32'd0);
    chk("first_write_tohost_before", m_if.tohost, 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("first_write_tohost", m_if.tohost, 32'h1);

    tick();
    drive(1'b1, 3'b001, 12'h51e, 32'hb, 5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("fail_code", {1'b0, m_if.tohost[31:1]}, 32'd5);

    tick();
    drive(1'b1, 3'b001, 12'h51e, 32'hf0, 5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b110, 12'h51e, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rsi_old", m_if.csr_rdata, 32'hf0);
    tick();
    drive(1'b1, 3'b011, 12'h51e, 32'h30, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rsi_result", m_if.tohost, 32'hf3);
    tick();
    drive(1'b1, 3'b010, 12'h51e, 32'hffff_ffff, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rc_result", m_if.tohost, 32'hc3);
    chk("rs_x0_illegal", {31'b0, m_if.illegal}, 32'd0);
    chk("rs_x0_rdata", m_if.csr_rdata, 32'hc3);
    tick();
    idle();
    @(negedge clk);
    chk("rs_x0_no_write", m_if.tohost, 32'hc3);

    tick();
    drive(1'b1, 3'b001, 12'h51e, 32'haa, 5'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stalled_hold", m_if.tohost, 32'hc3);
      tick();
    end
    m_if.stall = 1'b0;
    @(negedge clk);
    chk("stall_release_before_edge", m_if.tohost, 32'hc3);
    tick();
    idle();
    @(negedge clk);
    chk("stall_commit", m_if.tohost, 32'haa);

    tick();
    drive(1'b1, 3'b001, 12'h51e, 32'h55, 5'd1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("kill_no_write", m_if.tohost, 32'haa);

    tick();
    drive(1'b1, 3'b001, 12'h51e, 32'h77, 5'd1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("reset_beats_commit", m_if.tohost, 32'd0);

    tick();
    drive(1'b1, 3'b010, 12'hc00, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rd_a = m_if.csr_rdata;
    tick();
    @(negedge clk);
    rd_b = m_if.csr_rdata;
    chk("cycle_delta", rd_b - rd_a, 32'd1);

    for (int i = 0; i < 7; i++) begin
      tick();
      drive(1'b0, 3'b000, 12'h000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    drive(1'b1, 3'b010, 12'hc02, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("instret_seven", m_if.csr_rdata, 32'd7);

    tick();
    drive(1'b1, 3'b001, 12'hc00, 32'h1234, 5'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rw_counter_illegal", {31'b0, m_if.illegal}, 32'd1);
    tick();
    drive(1'b1, 3'b010, 12'h123, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("unknown_addr_illegal", {31'b0, m_if.illegal}, 32'd1);
    chk("unknown_addr_rdata", m_if.csr_rdata, 32'd0);
    tick();
    drive(1'b1, 3'b100, 12'h51e, 32'h99, 5'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("funct3_100_illegal", {31'b0, m_if.illegal}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("illegal_no_write", m_if.tohost, 32'd0);

    for (int i = 0; i < 400; i++) begin
      tick();
      case ($urandom_range(0, 6))
        0, 1:    raddr = 12'h51e;
        2:       raddr = 12'hc00;
        3:       raddr = 12'hc80;
        4:       raddr = 12'hc02;
        5:       raddr = 12'hc82;
        default: raddr = 12'($urandom_range(0, 4095));
      endcase
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), raddr, $urandom(),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1));
      rst = ($urandom_range(0, 49) == 0);
    end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
